// File: rtl/beta_alpha_update_fix.sv
// beta_alpha_update_fix: accumulate a frame of beta vectors per user, max-normalise, saturate to int8, stream alpha beats.
module beta_alpha_update_fix #(
  parameter int J = 4,
  parameter int I = 8,
  parameter int A = 4,
  parameter int DATAWIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [A*DATAWIDTH-1:0] beta,
  input  logic                   beta_tvalid,
  output logic [J*DATAWIDTH-1:0] alpha_u_col,
  output logic                   alpha_u_col_tvalid,
  output logic                   alpha_u_col_tlast,
  input  logic                   alpha_u_col_tready,
  output logic                   busy,
  output logic                   drop_err
);
  localparam int SW = DATAWIDTH + $clog2(I) + 1;
  localparam int KW = $clog2(I*J) > 0 ? $clog2(I*J) : 1;
  localparam int JW = $clog2(J) > 0 ? $clog2(J) : 1;
  localparam int AW = $clog2(A) > 0 ? $clog2(A) : 1;
  localparam logic signed [SW:0] LO = -(SW+1)'(2**(DATAWIDTH-1));
  typedef enum logic [1:0] {ACC, NORM, OUT} state_t;
  state_t state, state_n;
  logic [KW-1:0] k_cnt;
  logic [JW-1:0] j_cnt, kj;
  logic [AW-1:0] a_cnt, nxt_a;
  logic signed [SW-1:0] sum [J][A];
  logic signed [DATAWIDTH-1:0] res [J][A];
  logic signed [DATAWIDTH-1:0] nres [A];
  logic signed [SW:0] d [A];
  logic signed [SW-1:0] m;
  logic last_k, last_j, hs, fin, load;
  assign kj = JW'(k_cnt % J);
  assign last_k = k_cnt == KW'(I*J-1);
  assign last_j = j_cnt == JW'(J-1);
  assign hs = alpha_u_col_tvalid & alpha_u_col_tready;
  assign fin = hs & alpha_u_col_tlast;
  assign nxt_a = alpha_u_col_tvalid ? a_cnt + 1'b1 : a_cnt;
  assign load = state == OUT && (!alpha_u_col_tvalid || (hs && !alpha_u_col_tlast));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= ACC;
    else state <= state_n;
  always_comb begin
    state_n = state;
    busy = state != ACC;
    state_n = (state == ACC && beta_tvalid && last_k) ? NORM :
              (state == NORM && last_j)               ? OUT  :
              (state == OUT && fin)                   ? ACC  : state;
  end
  // Max tree for the user being normalised, then shift and clamp into [-128, 0]
  always_comb begin
    m = sum[j_cnt][0];
    for (int a = 1; a < A; a++) m = sum[j_cnt][a] > m ? sum[j_cnt][a] : m;
    for (int a = 0; a < A; a++) begin
      d[a] = (SW+1)'(sum[j_cnt][a]) - (SW+1)'(m);
      nres[a] = d[a] < LO ? LO[DATAWIDTH-1:0] : d[a][DATAWIDTH-1:0];
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int j = 0; j < J; j++)
        for (int a = 0; a < A; a++) begin
          sum[j][a] <= '0;
          res[j][a] <= '0;
        end
      k_cnt <= '0;
      j_cnt <= '0;
      a_cnt <= '0;
      alpha_u_col <= '0;
      alpha_u_col_tvalid <= 1'b0;
      alpha_u_col_tlast <= 1'b0;
      drop_err <= 1'b0;
    end else begin
      drop_err <= drop_err | (beta_tvalid && state != ACC);
      if (state == ACC && beta_tvalid) begin
        for (int a = 0; a < A; a++)
          sum[kj][a] <= sum[kj][a] + SW'($signed(beta[a*DATAWIDTH +: DATAWIDTH]));
        k_cnt <= last_k ? '0 : k_cnt + 1'b1;
      end
      if (state == NORM) begin
        for (int a = 0; a < A; a++) res[j_cnt][a] <= nres[a];
        j_cnt <= last_j ? '0 : j_cnt + 1'b1;
      end
      if (load) begin
        for (int j = 0; j < J; j++) alpha_u_col[j*DATAWIDTH +: DATAWIDTH] <= res[j][nxt_a];
        a_cnt <= nxt_a;
        alpha_u_col_tvalid <= 1'b1;
        alpha_u_col_tlast <= nxt_a == AW'(A-1);
      end
      if (state == OUT && fin) begin
        for (int j = 0; j < J; j++)
          for (int a = 0; a < A; a++) sum[j][a] <= '0;
        k_cnt <= '0;
        j_cnt <= '0;
        a_cnt <= '0;
        alpha_u_col_tvalid <= 1'b0;
        alpha_u_col_tlast <= 1'b0;
      end
    end
endmodule

// File: tb/tb_beta_alpha_update_fix.sv
// tb_beta_alpha_update_fix: table-driven frames, corner sequences and random frames against an arithmetic model.
module tb_beta_alpha_update_fix;
  logic clk = 0, rst_n = 0;
  logic [31:0] beta = 0, alpha;
  logic beta_tvalid = 0, tv, tl, tr = 0, busy, drop_err;
  int checks = 0, errors = 0;
  typedef struct { logic [31:0] lanes; logic [31:0] e; } vec_t;
  vec_t tbl [6];
  logic [31:0] fb [32];
  logic [31:0] got [4];
  logic [31:0] em [4];
  int lat;

  beta_alpha_update_fix dut (
    .clk(clk), .rst_n(rst_n), .beta(beta), .beta_tvalid(beta_tvalid),
    .alpha_u_col(alpha), .alpha_u_col_tvalid(tv), .alpha_u_col_tlast(tl),
    .alpha_u_col_tready(tr), .busy(busy), .drop_err(drop_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string n, input logic [31:0] g, input logic [31:0] e);
    checks++;
    if (g !== e) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", n, g, e);
    end
  endtask

  task automatic model();
    int s [4][4];
    int m, r;
    for (int j = 0; j < 4; j++) for (int a = 0; a < 4; a++) s[j][a] = 0;
    for (int k = 0; k < 32; k++)
      for (int a = 0; a < 4; a++) s[k % 4][a] += int'($signed(fb[k][a*8 +: 8]));
    for (int j = 0; j < 4; j++) begin
      m = s[j][0];
      for (int a = 1; a < 4; a++) if (s[j][a] > m) m = s[j][a];
      for (int a = 0; a < 4; a++) begin
        r = s[j][a] - m;
        if (r < -128) r = -128;
        em[a][j*8 +: 8] = 8'(r);
      end
    end
  endtask

  task automatic run_frame(input int stall_beat, input bit drop, input bit rnd);
    int nhs, stall, cyc;
    logic [31:0] hd;
    logic hl;
    for (int k = 0; k < 32; k++) begin
      beta = fb[k];
      beta_tvalid = 1;
      @(negedge clk);
    end
    beta_tvalid = 0;
    beta = 0;
    lat = 0;
    while (!tv && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("latency", lat, 5);
    check("busy_out", {31'b0, busy}, 1);
    nhs = 0; stall = 0; cyc = 0; hd = 0; hl = 0;
    while (nhs < 4 && cyc < 200) begin
      beta_tvalid = drop && nhs == 2;
      beta = {4{8'd100}};
      if (stall_beat == nhs && stall < 3) begin
        if (stall == 0) begin
          hd = alpha;
          hl = tl;
        end else begin
          check("stall_data", alpha, hd);
          check("stall_tvalid", {31'b0, tv}, 1);
          check("stall_tlast", {31'b0, tl}, {31'b0, hl});
        end
        tr = 0;
        stall++;
      end else if (rnd && $urandom_range(0, 2) == 0) tr = 0;
      else begin
        tr = 1;
        if (tv) begin
          got[nhs] = alpha;
          check("tlast", {31'b0, tl}, {31'b0, nhs == 3});
          nhs++;
        end
      end
      @(negedge clk);
      cyc++;
    end
    beta_tvalid = 0;
    beta = 0;
    tr = 0;
    check("handshakes", nhs, 4);
    check("tvalid_after", {31'b0, tv}, 0);
    check("busy_after", {31'b0, busy}, 0);
    check("alpha_hold", alpha, got[3]);
  endtask

  initial begin
    tbl[0] = '{32'h01010101, 32'h00000000};
    tbl[1] = '{32'h1E140A00, 32'h00B08080};
    tbl[2] = '{32'h7F7F7F80, 32'h00000080};
    tbl[3] = '{32'h0200FD05, 32'hE8D8C000};
    tbl[4] = '{32'h80808080, 32'h00000000};
    tbl[5] = '{32'hFF00807F, 32'h80808000};
    repeat (3) @(negedge clk);
    check("rst_alpha", alpha, 0);
    check("rst_ctl", {28'b0, tv, tl, busy, drop_err}, 0);
    rst_n = 1;
    @(negedge clk);
    for (int t = 0; t < 6; t++) begin
      for (int k = 0; k < 32; k++) fb[k] = tbl[t].lanes;
      run_frame(-1, 0, 0);
      for (int a = 0; a < 4; a++) check($sformatf("tbl%0d_beat%0d", t, a), got[a], {4{tbl[t].e[a*8 +: 8]}});
    end
    check("drop_clean", {31'b0, drop_err}, 0);
    for (int k = 0; k < 32; k++) fb[k] = tbl[1].lanes;
    run_frame(1, 0, 0);
    for (int a = 0; a < 4; a++) check($sformatf("bp_beat%0d", a), got[a], {4{tbl[1].e[a*8 +: 8]}});
    for (int k = 0; k < 32; k++) fb[k] = tbl[0].lanes;
    run_frame(-1, 1, 0);
    check("drop_err_set", {31'b0, drop_err}, 1);
    for (int a = 0; a < 4; a++) check($sformatf("drop_beat%0d", a), got[a], 0);
    for (int k = 0; k < 32; k++) fb[k] = tbl[3].lanes;
    run_frame(-1, 0, 0);
    for (int a = 0; a < 4; a++) check($sformatf("post_drop_beat%0d", a), got[a], {4{tbl[3].e[a*8 +: 8]}});
    for (int k = 0; k < 17; k++) begin
      beta = {4{8'd100}};
      beta_tvalid = 1;
      @(negedge clk);
    end
    beta_tvalid = 0;
    rst_n = 0;
    #1;
    check("midrst_ctl", {28'b0, tv, tl, busy, drop_err}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    for (int k = 0; k < 32; k++) fb[k] = tbl[1].lanes;
    run_frame(-1, 0, 0);
    for (int a = 0; a < 4; a++) check($sformatf("midrst_beat%0d", a), got[a], {4{tbl[1].e[a*8 +: 8]}});
    check("midrst_drop", {31'b0, drop_err}, 0);
    for (int f = 0; f < 5; f++) begin
      for (int k = 0; k < 32; k++) fb[k] = f == 4 ? ($urandom_range(0, 1) ? 32'h7F7F7F7F : 32'h80808080) ^ ($urandom & 32'h01010101) : $urandom;
      model();
      run_frame(-1, 0, 1);
      for (int a = 0; a < 4; a++) check($sformatf("rnd%0d_beat%0d", f, a), got[a], em[a]);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
